// File: rtl/wb_arb_if.sv
// ---------------------------------------------------------------------------
// wb_arb_if
// Writeback bus between the functional-unit result channels and the
// register-file write port.
//
// Channel side (driven by the FUs, one slice per channel):
//   ch_dst     [NUM_CH*5]     destination register, channel i at [i*5 +: 5]
//   ch_result  [NUM_CH*XLEN]  result, channel i at [i*XLEN +: XLEN]
//   ch_pc      [NUM_CH*XLEN]  instruction PC, channel i at [i*XLEN +: XLEN]
//   ch_wb_en   [NUM_CH]       register write enable
//   ch_valid   [NUM_CH]       result valid (held until ch_ready seen)
//   ch_ready   [NUM_CH]       grant back to the channel, one-hot or zero
// Register-file / retire side (driven by the arbiter):
//   rf_wen, rf_wdst, rf_wdata, wb_pc, wb_retire, wb_instret
//
// Modports:
//   slave  - the arbiter (consumes channel requests, drives the rf side)
//   master - the FU / environment side
// ---------------------------------------------------------------------------
interface wb_arb_if #(
    parameter int NUM_CH = 2,
    parameter int XLEN   = 64
);
    logic [NUM_CH*5-1:0]    ch_dst;
    logic [NUM_CH*XLEN-1:0] ch_result;
    logic [NUM_CH*XLEN-1:0] ch_pc;
    logic [NUM_CH-1:0]      ch_wb_en;
    logic [NUM_CH-1:0]      ch_valid;
    logic [NUM_CH-1:0]      ch_ready;

    logic                   rf_wen;
    logic [4:0]             rf_wdst;
    logic [XLEN-1:0]        rf_wdata;
    logic [XLEN-1:0]        wb_pc;
    logic                   wb_retire;
    logic [63:0]            wb_instret;

    modport slave (
        input  ch_dst, ch_result, ch_pc, ch_wb_en, ch_valid,
        output ch_ready,
        output rf_wen, rf_wdst, rf_wdata, wb_pc, wb_retire, wb_instret
    );

    modport master (
        output ch_dst, ch_result, ch_pc, ch_wb_en, ch_valid,
        input  ch_ready,
        input  rf_wen, rf_wdst, rf_wdata, wb_pc, wb_retire, wb_instret
    );
endinterface

// File: rtl/wb_arb.sv
// ---------------------------------------------------------------------------
// wb_arb
// N-channel writeback arbiter. Each cycle at most one valid FU result is
// granted (combinational ch_ready) and registered onto the single register
// file write port one cycle later. Also keeps the retired-instruction count.
//
// Parameters:
//   NUM_CH   number of writeback channels (>=1), index 0 = highest priority
//   XLEN     result / PC width
//   ARB_MODE 0 = round-robin, 1 = fixed priority (lowest index wins)
// Ports:
//   clk  clock
//   rst  asynchronous reset, active high
//   bus  wb_arb_if.slave: channel requests in, ch_ready and rf/retire out
// ---------------------------------------------------------------------------
module wb_arb #(
    parameter int NUM_CH   = 2,
    parameter int XLEN     = 64,
    parameter int ARB_MODE = 0
) (
    input  logic     clk,
    input  logic     rst,
    wb_arb_if.slave  bus
);
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] req_hi;      // requests at or above the rr pointer
    logic [NUM_CH-1:0] grant_oh;
    logic [PTR_W-1:0]  grant_idx;
    logic              any_grant;

    logic [PTR_W-1:0]  rr_ptr_reg;
    logic [PTR_W-1:0]  rr_ptr_next;

    logic [4:0]        sel_dst;
    logic [XLEN-1:0]   sel_result;
    logic [XLEN-1:0]   sel_pc;
    logic              sel_wb_en;

    logic              rf_wen_reg;
    logic [4:0]        rf_wdst_reg;
    logic [XLEN-1:0]   rf_wdata_reg;
    logic [XLEN-1:0]   wb_pc_reg;
    logic              wb_retire_reg;
    logic [63:0]       instret_reg;

    // Isolate the lowest set bit: v & -v.
    function automatic logic [NUM_CH-1:0] lowest_one(input logic [NUM_CH-1:0] v);
        return v & (~v + NUM_CH'(1));
    endfunction

    assign req       = bus.ch_valid;
    assign any_grant = |req;

    // Round-robin is done with a thermometer mask instead of a rotating
    // scan: requests at index >= rr_ptr win first; if none exist the search
    // wraps to the lowest-index request overall.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_req_hi
            assign req_hi[gi] = req[gi] & (PTR_W'(gi) >= rr_ptr_reg);
        end

        if (ARB_MODE == 1) begin : g_fixed
            assign grant_oh = lowest_one(req);
        end else begin : g_rr
            assign grant_oh = (|req_hi) ? lowest_one(req_hi) : lowest_one(req);
        end
    endgenerate

    // One-hot grant -> index and AND-OR data mux.
    always_comb begin
        grant_idx  = '0;
        sel_dst    = '0;
        sel_result = '0;
        sel_pc     = '0;
        sel_wb_en  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_oh[i]) begin
                grant_idx  = grant_idx | PTR_W'(i);
                sel_dst    = sel_dst | bus.ch_dst[i*5 +: 5];
                sel_result = sel_result | bus.ch_result[i*XLEN +: XLEN];
                sel_pc     = sel_pc | bus.ch_pc[i*XLEN +: XLEN];
                sel_wb_en  = sel_wb_en | bus.ch_wb_en[i];
            end
        end
    end

    // Pointer moves to the channel after the one just granted; with a single
    // channel there is nothing to rotate and the pointer is tied to zero.
    generate
        if (NUM_CH > 1) begin : g_rr_ptr
            always_comb begin
                rr_ptr_next = rr_ptr_reg;
                if (any_grant && (ARB_MODE == 0)) begin
                    rr_ptr_next = (grant_idx == PTR_W'(NUM_CH - 1)) ? '0
                                                                     : grant_idx + PTR_W'(1);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rr_ptr_reg <= '0;
                end else begin
                    rr_ptr_reg <= rr_ptr_next;
                end
            end
        end else begin : g_no_ptr
            assign rr_ptr_next = '0;
            assign rr_ptr_reg  = '0;
        end
    endgenerate

    // Output stage. Data/index/PC registers only load on a grant so they
    // keep the last written values while idle. An asynchronous reset clears
    // the retire/write strobes, which drops any result still in this stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen_reg    <= 1'b0;
            rf_wdst_reg   <= '0;
            rf_wdata_reg  <= '0;
            wb_pc_reg     <= '0;
            wb_retire_reg <= 1'b0;
            instret_reg   <= '0;
        end else begin
            rf_wen_reg    <= any_grant & sel_wb_en & (sel_dst != 5'd0);
            wb_retire_reg <= any_grant;
            if (any_grant) begin
                rf_wdst_reg  <= sel_dst;
                rf_wdata_reg <= sel_result;
                wb_pc_reg    <= sel_pc;
                // Counts the retire pulse that becomes visible at this edge;
                // wraps naturally at 2^64.
                instret_reg  <= instret_reg + 64'd1;
            end
        end
    end

    assign bus.ch_ready   = grant_oh;
    assign bus.rf_wen     = rf_wen_reg;
    assign bus.rf_wdst    = rf_wdst_reg;
    assign bus.rf_wdata   = rf_wdata_reg;
    assign bus.wb_pc      = wb_pc_reg;
    assign bus.wb_retire  = wb_retire_reg;
    assign bus.wb_instret = instret_reg;
endmodule

// File: tb/tb_wb_arb.sv
// ---------------------------------------------------------------------------
// tb_wb_arb
// Drives four arbiter instances side by side from one clock:
//   d0: NUM_CH=2 round-robin   d1: NUM_CH=2 fixed priority
//   d2: NUM_CH=3 round-robin   d3: NUM_CH=1
// Each instance is compared every cycle against a behavioural model that
// scans the channels from the pointer (or from 0) and tracks the expected
// registered outputs and retire count.
// ---------------------------------------------------------------------------
module tb_wb_arb;
    localparam int ND   = 4;
    localparam int MAXC = 3;
    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Per-instance channel stimulus.
    logic        st_v  [ND][MAXC];
    logic [4:0]  st_d  [ND][MAXC];
    logic [63:0] st_r  [ND][MAXC];
    logic [63:0] st_p  [ND][MAXC];
    logic        st_we [ND][MAXC];

    // Observed outputs per instance.
    wire [MAXC-1:0] o_rdy     [ND];
    wire            o_wen     [ND];
    wire            o_ret     [ND];
    wire [4:0]      o_dst     [ND];
    wire [63:0]     o_data    [ND];
    wire [63:0]     o_pc      [ND];
    wire [63:0]     o_instret [ND];

    generate
        for (genvar gi = 0; gi < ND; gi++) begin : g_dut
            localparam int NC   = (gi == 2) ? 3 : ((gi == 3) ? 1 : 2);
            localparam int MODE = (gi == 1) ? 1 : 0;

            logic [NC-1:0]      vv, ww;
            logic [NC*5-1:0]    dd;
            logic [NC*XLEN-1:0] rr, pp;

            always_comb begin
                vv = '0;
                ww = '0;
                dd = '0;
                rr = '0;
                pp = '0;
                for (int c = 0; c < NC; c++) begin
                    vv[c]             = st_v[gi][c];
                    ww[c]             = st_we[gi][c];
                    dd[c*5 +: 5]      = st_d[gi][c];
                    rr[c*XLEN +: XLEN] = st_r[gi][c];
                    pp[c*XLEN +: XLEN] = st_p[gi][c];
                end
            end

            wb_arb_if #(.NUM_CH(NC), .XLEN(XLEN)) bus ();

            assign bus.ch_valid  = vv;
            assign bus.ch_wb_en  = ww;
            assign bus.ch_dst    = dd;
            assign bus.ch_result = rr;
            assign bus.ch_pc     = pp;

            wb_arb #(.NUM_CH(NC), .XLEN(XLEN), .ARB_MODE(MODE)) dut (
                .clk (clk),
                .rst (rst),
                .bus (bus)
            );

            assign o_rdy[gi]     = MAXC'(bus.ch_ready);
            assign o_wen[gi]     = bus.rf_wen;
            assign o_ret[gi]     = bus.wb_retire;
            assign o_dst[gi]     = bus.rf_wdst;
            assign o_data[gi]    = bus.rf_wdata;
            assign o_pc[gi]      = bus.wb_pc;
            assign o_instret[gi] = bus.wb_instret;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    int          m_ptr     [ND];
    int          m_grant   [ND];
    logic [63:0] m_instret [ND];
    logic        m_wen     [ND];
    logic        m_ret     [ND];
    logic [4:0]  m_dst     [ND];
    logic [63:0] m_data    [ND];
    logic [63:0] m_pc      [ND];
    logic [MAXC-1:0] obs_rdy [ND];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    function automatic int nch_of(input int k);
        return (k == 2) ? 3 : ((k == 3) ? 1 : 2);
    endfunction

    function automatic bit fixed_of(input int k);
        return (k == 1);
    endfunction

    // Which channel the arbiter should grant right now, -1 if none.
    function automatic int pick(input int k);
        int n;
        int c;
        n = nch_of(k);
        for (int off = 0; off < n; off++) begin
            c = fixed_of(k) ? off : (m_ptr[k] + off) % n;
            if (st_v[k][c]) return c;
        end
        return -1;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < ND; k++) begin
            m_ptr[k]     = 0;
            m_grant[k]   = -1;
            m_instret[k] = '0;
            m_wen[k]     = 1'b0;
            m_ret[k]     = 1'b0;
            m_dst[k]     = '0;
            m_data[k]    = '0;
            m_pc[k]      = '0;
        end
    endtask

    task automatic clear_all();
        for (int k = 0; k < ND; k++)
            for (int c = 0; c < MAXC; c++) begin
                st_v[k][c]  = 1'b0;
                st_d[k][c]  = '0;
                st_r[k][c]  = '0;
                st_p[k][c]  = '0;
                st_we[k][c] = 1'b0;
            end
    endtask

    task automatic set_ch(input int k, input int c, input logic [4:0] d,
                          input logic [63:0] r, input logic we);
        st_v[k][c]  = 1'b1;
        st_d[k][c]  = d;
        st_r[k][c]  = r;
        st_p[k][c]  = 64'h1000 + 64'(k*256 + c*16) + r;
        st_we[k][c] = we;
    endtask

    task automatic check_regs();
        for (int k = 0; k < ND; k++) begin
            check_val($sformatf("d%0d_wen", k),     64'(o_wen[k]),  64'(m_wen[k]));
            check_val($sformatf("d%0d_retire", k),  64'(o_ret[k]),  64'(m_ret[k]));
            check_val($sformatf("d%0d_instret", k), o_instret[k],   m_instret[k]);
            check_val($sformatf("d%0d_wdst", k),    64'(o_dst[k]),  64'(m_dst[k]));
            check_val($sformatf("d%0d_wdata", k),   o_data[k],      m_data[k]);
            check_val($sformatf("d%0d_wbpc", k),    o_pc[k],        m_pc[k]);
        end
    endtask

    // One clock: check grants shortly after the inputs settle, advance the
    // model at the edge, check registered outputs on the falling edge.
    task automatic step();
        int g;
        #1;
        for (int k = 0; k < ND; k++) begin
            g = pick(k);
            m_grant[k] = g;
            obs_rdy[k] = o_rdy[k];
            check_val($sformatf("d%0d_ready", k), 64'(o_rdy[k]),
                      (g >= 0) ? (64'd1 << g) : 64'd0);
        end
        @(posedge clk);
        for (int k = 0; k < ND; k++) begin
            g = m_grant[k];
            if (g >= 0) begin
                m_ret[k]     = 1'b1;
                m_wen[k]     = st_we[k][g] && (st_d[k][g] != 5'd0);
                m_dst[k]     = st_d[k][g];
                m_data[k]    = st_r[k][g];
                m_pc[k]      = st_p[k][g];
                m_instret[k] = m_instret[k] + 64'd1;
                if (!fixed_of(k)) m_ptr[k] = (g + 1) % nch_of(k);
            end else begin
                m_ret[k] = 1'b0;
                m_wen[k] = 1'b0;
            end
        end
        @(negedge clk);
        cyc++;
        check_regs();
        $display("cyc=%0d grant d0=%0d d1=%0d d2=%0d d3=%0d", cyc,
                 m_grant[0], m_grant[1], m_grant[2], m_grant[3]);
    endtask

    // Granted or idle channels may present a new random transfer; channels
    // still waiting keep their request untouched.
    task automatic refresh(input int pct);
        for (int k = 0; k < ND; k++)
            for (int c = 0; c < nch_of(k); c++)
                if (!st_v[k][c] || m_grant[k] == c) begin
                    st_v[k][c]  = ($urandom_range(99) < pct);
                    st_d[k][c]  = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
                    st_r[k][c]  = {$urandom, $urandom};
                    st_p[k][c]  = {$urandom, $urandom};
                    st_we[k][c] = ($urandom_range(3) != 0);
                end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_all();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        clear_all();
        model_reset();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        for (int k = 0; k < ND; k++)
            check_val($sformatf("rst_d%0d_ready", k), 64'(o_rdy[k]), 64'd0);
        check_regs();
        rst = 1'b0;
        @(negedge clk);

        // T1: single transfer on ch0 of d0
        set_ch(0, 0, 5'd5, 64'h1234, 1'b1);
        step();
        check_val("t1_ready",   64'(obs_rdy[0]), 64'b01);
        check_val("t1_wen",     64'(o_wen[0]),   64'd1);
        check_val("t1_wdst",    64'(o_dst[0]),   64'd5);
        check_val("t1_wdata",   o_data[0],       64'h1234);
        check_val("t1_instret", o_instret[0],    64'd1);

        // T2 (d0 round-robin) and T3 (d1 fixed priority) in the same cycles
        do_reset();
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 2; c++) begin
                set_ch(0, c, 5'(10 + c), 64'hA000 + 64'(i*2 + c), 1'b1);
                set_ch(1, c, 5'(20 + c), 64'hB000 + 64'(i*2 + c), 1'b1);
            end
            step();
            check_val("t2_grant_seq", 64'(obs_rdy[0]), (i % 2 == 0) ? 64'b01 : 64'b10);
            check_val("t2_wdata",     o_data[0],       64'hA000 + 64'(i*2 + i%2));
            if (i < 3) check_val("t3_fixed_grant", 64'(obs_rdy[1]), 64'b01);
        end
        check_val("t2_instret", o_instret[0], 64'd4);
        clear_all();

        // T4: retire without register write (dst=x0, then wb_en=0)
        set_ch(0, 1, 5'd0, 64'hDEAD, 1'b1);
        step();
        check_val("t4_wen_a",    64'(o_wen[0]), 64'd0);
        check_val("t4_retire_a", 64'(o_ret[0]), 64'd1);
        set_ch(0, 1, 5'd7, 64'hBEEF, 1'b0);
        step();
        check_val("t4_wen_b",    64'(o_wen[0]), 64'd0);
        check_val("t4_retire_b", 64'(o_ret[0]), 64'd1);
        check_val("t4_instret",  o_instret[0],  64'd6);
        clear_all();
        step();
        check_val("t4_idle_retire", 64'(o_ret[0]), 64'd0);

        // T5: counter wrap
        force g_dut[0].dut.instret_reg = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release g_dut[0].dut.instret_reg;
        m_instret[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        check_val("t5_preload", o_instret[0], 64'hFFFF_FFFF_FFFF_FFFF);
        set_ch(0, 0, 5'd3, 64'h55, 1'b1);
        step();
        check_val("t5_wrap", o_instret[0], 64'd0);
        clear_all();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            refresh((i < 200) ? 60 : 95);
            step();
        end

        // T6: reset between a grant and the next edge
        clear_all();
        step();
        set_ch(2, 0, 5'd1, 64'h77, 1'b1);
        step();                              // d2 pointer now at channel 1
        for (int k = 0; k < ND; k++)
            for (int c = 0; c < nch_of(k); c++)
                set_ch(k, c, 5'(c + 1), 64'h9000 + 64'(k*4 + c), 1'b1);
        #1;
        check_val("t6_pre_ready", 64'(o_rdy[2]), 64'b010);
        #1;
        rst = 1'b1;
        #1;
        for (int k = 0; k < ND; k++) begin
            check_val($sformatf("t6_d%0d_wen", k),     64'(o_wen[k]), 64'd0);
            check_val($sformatf("t6_d%0d_retire", k),  64'(o_ret[k]), 64'd0);
            check_val($sformatf("t6_d%0d_instret", k), o_instret[k],  64'd0);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step();
        check_val("t6_restart_ch0", 64'(obs_rdy[2]), 64'b001);
        check_val("t6_restart_cnt", o_instret[2], 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
